// File: rtl/i2s_tx.sv
// I2S transmitter: clk_in-derived bclk, word select and MSB-first serial data
// with a one-entry holding register. Define I2S_TX_UNDERRUN_CNT_EN to add underrun_cnt.
module i2s_tx #(
  parameter int unsigned BCLK_DIV     = 2,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int unsigned   FW       = 2 * SAMPLE_WIDTH;
  localparam int unsigned   BW       = $clog2(FW);
  localparam logic [7:0]    DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(SAMPLE_WIDTH);

  logic [7:0]    r_div_cnt;
  logic          r_bclk;
  logic          r_lrclk;
  logic          r_sdata;
  logic [BW-1:0] r_bit_cnt;
  logic          r_hold_full;
  logic [FW-1:0] r_hold;
  logic [FW-1:0] r_frame;
  logic          r_underrun;

  logic          w_tc;
  logic          w_fall;
  logic          w_latch;
  logic          w_hs;
  logic          w_starve;
  logic [BW-1:0] w_bit_nxt;
  logic [FW-1:0] w_pair;

  always_comb begin
    w_tc      = (r_div_cnt == DIV_LAST);
    w_fall    = w_tc && r_bclk;
    w_latch   = w_fall && (r_bit_cnt == BIT_LAST);
    w_hs      = sample_valid && !r_hold_full;
    w_starve  = w_latch && !r_hold_full && !w_hs;
    w_bit_nxt = w_latch ? '0 : r_bit_cnt + 1'b1;
    w_pair    = {sample_l, sample_r};
  end

  // r_frame shifts left once per non-latch fall, so after the last bit of a
  // frame its MSB holds the previous right LSB that the latch slot sends.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_bclk      <= 1'b1;
      r_lrclk     <= 1'b1;
      r_sdata     <= 1'b0;
      r_bit_cnt   <= BIT_LAST;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_frame     <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;

      if (w_tc) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end

      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= (w_bit_nxt >= BIT_HALF);
        r_sdata   <= r_frame[FW-1];
        if (w_latch) begin
          if (r_hold_full) begin
            r_frame <= r_hold;
          end else if (w_hs) begin
            r_frame <= w_pair;
          end else begin
            r_frame    <= '0;
            r_underrun <= 1'b1;
          end
        end else begin
          r_frame <= {r_frame[FW-2:0], 1'b0};
        end
      end

      if (w_latch && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_hs && !w_latch) begin
        r_hold      <= w_pair;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    sample_ready = !r_hold_full;
    bclk         = r_bclk;
    lrclk        = r_lrclk;
    sdata        = r_sdata;
    underrun     = r_underrun;
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_underrun_cnt <= '0;
    end else if (w_starve && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  always_comb underrun_cnt = r_underrun_cnt;
`endif

endmodule
